// File: rtl/edf_request_scheduler.sv
// Earliest-deadline-first request arbiter: per-requester aging deadlines,
// minimum-remaining-time selection and a valid/ready grant handshake.
module edf_request_scheduler #(
    parameter int NB_REQ   = 4,
    parameter int DL_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NB_REQ*DL_WIDTH-1:0]   period,
    input  logic [NB_REQ-1:0]            req_valid,
    output logic [NB_REQ-1:0]            req_ready,
    output logic                         grant_valid,
    output logic [$clog2(NB_REQ)-1:0]    grant_id,
    input  logic                         grant_ready,
    output logic [NB_REQ-1:0]            deadline_miss
);

    localparam int IDW = $clog2(NB_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_GRANT
    } state_e;

    state_e                state_q, state_d;
    logic [NB_REQ-1:0]     pending_q, pending_d;
    logic [NB_REQ-1:0]     miss_q, miss_d;
    logic [DL_WIDTH-1:0]   rem_q [NB_REQ];
    logic [DL_WIDTH-1:0]   rem_d [NB_REQ];
    logic [IDW-1:0]        gid_q, gid_d;

    logic [IDW-1:0]        win_id;
    logic [DL_WIDTH-1:0]   win_rem;
    logic                  win_found;
    logic [NB_REQ-1:0]     gid_oh;
    logic                  hs;
    logic                  other_pend;

    assign gid_oh     = NB_REQ'(1) << gid_q;
    assign hs         = (state_q == S_GRANT) & grant_ready;
    assign other_pend = |(pending_q & ~gid_oh);

    // Strict less-than keeps the lowest index on equal deadlines
    always_comb begin
        win_id    = '0;
        win_rem   = '1;
        win_found = 1'b0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (pending_q[i] && (!win_found || rem_q[i] < win_rem)) begin
                win_found = 1'b1;
                win_rem   = rem_q[i];
                win_id    = IDW'(i);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        miss_d    = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            rem_d[i] = rem_q[i];
            if (req_valid[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                rem_d[i]     = period[i*DL_WIDTH +: DL_WIDTH];
            end else if (pending_q[i]) begin
                if (rem_q[i] != '0) begin
                    rem_d[i] = rem_q[i] - DL_WIDTH'(1);
                end
                miss_d[i] = (rem_q[i] == DL_WIDTH'(1));
            end
        end
        if (hs) begin
            pending_d[gid_q] = 1'b0;
        end
    end

    always_comb begin
        gid_d = gid_q;
        if (state_q == S_SELECT && win_found) begin
            gid_d = win_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            miss_q    <= '0;
            gid_q     <= '0;
            for (int i = 0; i < NB_REQ; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            miss_q    <= miss_d;
            gid_q     <= gid_d;
            for (int i = 0; i < NB_REQ; i++) begin
                rem_q[i] <= rem_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (|pending_q) state_d = S_SELECT;
            end
            S_SELECT: begin
                state_d = win_found ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                if (grant_ready) state_d = other_pend ? S_SELECT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_valid   = (state_q == S_GRANT);
        grant_id      = gid_q;
        req_ready     = hs ? gid_oh : '0;
        deadline_miss = miss_q;
    end

endmodule

// File: tb/tb_edf_request_scheduler.sv
// Bench for edf_request_scheduler: table-driven EDF orderings checked
// through a grant scoreboard, plus stall, miss and reset sequences.
module tb_edf_request_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] period = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        grant_ready = 1'b0;
    logic [3:0]  deadline_miss;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int id;
        int cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [63:0] per;
        logic [3:0]  mask;
        int          n;
        logic [7:0]  ord;
    } vec_t;

    edf_request_scheduler #(.NB_REQ(4), .DL_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .period        (period),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .grant_ready   (grant_ready),
        .deadline_miss (deadline_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Every handshake is matched against the next expected grant
    always @(negedge clk) begin
        if (!reset && grant_valid && grant_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant act=%0d exp=none", grant_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant_id", 64'(grant_id), 64'(e.id));
                if (e.cyc >= 0) chk("grant_cycle", 64'(cyc), 64'(e.cyc));
                chk("req_ready", 64'(req_ready), 64'(4'b0001 << e.id));
            end
        end else if (req_ready != 4'b0000) begin
            total++;
            bad++;
            $display("FAIL stray_req_ready act=%0h exp=0", req_ready);
        end
    end

    task automatic drain(input string nm);
        for (int w = 0; w < 80 && sb.size() != 0; w++) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout act=%0d left exp=0", nm, sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic wait_gv(input string nm);
        for (int w = 0; w < 20 && !grant_valid; w++) tick();
        chk(nm, 64'(grant_valid), 64'd1);
    endtask

    task automatic arrive(input logic [3:0] m, input logic [63:0] p,
                          output int k);
        period    = p;
        req_valid = m;
        k         = cyc + 1;
        tick();
        req_valid = '0;
    endtask

    vec_t vt[7];

    initial begin
        int k;
        vt[0] = '{{16'd0, 16'd5, 16'd0, 16'd0}, 4'b0100, 1,
                  {2'd0, 2'd0, 2'd0, 2'd2}};
        vt[1] = '{{16'd30, 16'd12, 16'd7, 16'd20}, 4'b1111, 4,
                  {2'd3, 2'd0, 2'd2, 2'd1}};
        vt[2] = '{{16'd10, 16'd10, 16'd10, 16'd10}, 4'b1111, 4,
                  {2'd3, 2'd2, 2'd1, 2'd0}};
        vt[3] = '{{16'd30, 16'd0, 16'd40, 16'd0}, 4'b1111, 4,
                  {2'd1, 2'd3, 2'd2, 2'd0}};
        vt[4] = '{{16'd50, 16'd60, 16'd1, 16'd2}, 4'b1111, 4,
                  {2'd2, 2'd3, 2'd0, 2'd1}};
        vt[5] = '{{16'h00FF, 16'h0100, 16'h7FFF, 16'h8000}, 4'b1111, 4,
                  {2'd0, 2'd1, 2'd2, 2'd3}};
        vt[6] = '{{16'd4, 16'd0, 16'd9, 16'd0}, 4'b1010, 2,
                  {2'd0, 2'd0, 2'd1, 2'd3}};

        tick();
        tick();
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_miss", 64'(deadline_miss), 64'd0);
        reset = 1'b0;
        tick();

        // EDF ordering, latency and single bubble between grants
        grant_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            k = cyc + 1;
            for (int j = 0; j < vt[v].n; j++) begin
                sb.push_back('{int'(vt[v].ord[2*j +: 2]), k + 2 + 2*j});
            end
            arrive(vt[v].mask, vt[v].per, k);
            drain("table");
        end

        // No preemption by a later, more urgent arrival
        grant_ready = 1'b0;
        arrive(4'b0001, {48'd0, 16'd50}, k);
        wait_gv("np_gv_up");
        arrive(4'b1000, {16'd2, 48'd0}, k);
        for (int j = 0; j < 4; j++) begin
            chk("np_hold_gv", 64'(grant_valid), 64'd1);
            chk("np_hold_id", 64'(grant_id), 64'd0);
            tick();
        end
        sb.push_back('{0, -1});
        sb.push_back('{3, -1});
        grant_ready = 1'b1;
        drain("nopreempt");

        // Miss pulse timing; a zero period never pulses
        grant_ready = 1'b0;
        arrive(4'b0001, {48'd0, 16'd50}, k);
        wait_gv("miss_gv_up");
        arrive(4'b0110, {16'd0, 16'd0, 16'd3, 16'd0}, k);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("miss_k+%0d", j), 64'(deadline_miss),
                (j == 3) ? 64'h2 : 64'h0);
            tick();
        end
        sb.push_back('{0, -1});
        sb.push_back('{1, -1});
        sb.push_back('{2, -1});
        grant_ready = 1'b1;
        drain("miss");

        // Reset while a grant is offered
        grant_ready = 1'b0;
        arrive(4'b0100, {16'd0, 16'd5, 32'd0}, k);
        wait_gv("rst_gv_up");
        grant_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_gv", 64'(grant_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_miss", 64'(deadline_miss), 64'd0);
        chk("mid_rst_id", 64'(grant_id), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("post_rst_gv", 64'(grant_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
